// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage branch interlock controller.
package branch_hazard_ctrl_pkg;

  // Interlock FSM encoding: RUN lets the pipe flow, STALL holds PC and IF/ID.
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Register-file index width and the hardwired zero register.
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // A source operand depends on a load still in flight when that load writes a real
  // register (not r0) and its destination is the register being read.
  function automatic logic hazard_match(
    input logic [REG_W-1:0] sel,
    input logic [REG_W-1:0] dst,
    input logic             we,
    input logic             ld
  );
    return we && ld && (dst != ZERO_REG) && (dst == sel);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear; it stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // The clear wins over counting, and an enabled count never wraps past all-ones.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch interlock controller: stalls PC and IF/ID while a branch (or an ordinary
// instruction) waits on a load result that forwarding cannot supply yet, inserts
// ID/EX bubbles, squashes the fetched instruction after a taken branch and counts
// stalled cycles.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_EX_STALL  = 2,
  parameter int LOAD_MEM_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Branch,
  input  logic             BranchTaken,
  input  logic             UsesRs,
  input  logic             UsesRt,
  input  logic [REG_W-1:0] rfReSel1,
  input  logic [REG_W-1:0] rfReSel2,
  input  logic             RegW_EX,
  input  logic             MemR_EX,
  input  logic [REG_W-1:0] EX_rfWeSel,
  input  logic             RegW_MEM,
  input  logic             MemR_MEM,
  input  logic [REG_W-1:0] MEM_rfWeSel,
  output logic             PcWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [1:0] EX_NEED  = 2'(LOAD_EX_STALL);
  localparam logic [1:0] MEM_NEED = 2'(LOAD_MEM_STALL);

  state_t     state, state_nxt;
  logic [1:0] left, left_nxt;

  logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic [1:0] ex_need, mem_need, need;

  assign ex_hit1  = hazard_match(rfReSel1, EX_rfWeSel,  RegW_EX,  MemR_EX);
  assign ex_hit2  = hazard_match(rfReSel2, EX_rfWeSel,  RegW_EX,  MemR_EX);
  assign mem_hit1 = hazard_match(rfReSel1, MEM_rfWeSel, RegW_MEM, MemR_MEM);
  assign mem_hit2 = hazard_match(rfReSel2, MEM_rfWeSel, RegW_MEM, MemR_MEM);

  // Stall length needed by the instruction in ID; branches resolve in ID so they
  // also wait on MEM loads, other instructions only on a load still in EX.
  always_comb begin
    ex_need  = '0;
    mem_need = '0;
    if (Branch) begin
      if (ex_hit1 || ex_hit2)   ex_need  = EX_NEED;
      if (mem_hit1 || mem_hit2) mem_need = MEM_NEED;
    end else if ((UsesRs && ex_hit1) || (UsesRt && ex_hit2)) begin
      ex_need = 2'd1;
    end
    need = (ex_need > mem_need) ? ex_need : mem_need;
  end

  // State and remaining-stall registers; reset aborts any stall in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      left  <= '0;
    end else begin
      state <= state_nxt;
      left  <= left_nxt;
    end
  end

  // Next-state and pipeline control; the first stall cycle is issued from RUN and
  // STALL covers the rest, so the total bubble count equals the computed need.
  always_comb begin
    state_nxt   = state;
    left_nxt    = left;
    PcWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    unique case (state)
      RUN: begin
        if (need == 2'd0) begin
          IFID_Flush = Branch && BranchTaken;
        end else begin
          PcWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          if (need > 2'd1) begin
            state_nxt = STALL;
            left_nxt  = need - 2'd1;
          end
        end
      end
      STALL: begin
        PcWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
        if (left <= 2'd1) begin
          state_nxt = RUN;
          left_nxt  = '0;
        end else begin
          left_nxt = left - 2'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        left_nxt  = '0;
      end
    endcase
    if (Rst) begin
      PcWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (Clk),
    .clear (Rst),
    .enable(~PcWrite),
    .count (StallCnt)
  );

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Pipeline interlock controller for the ID-stage branch unit. It detects operand hazards that the branch forwarding muxes cannot cover, which are load results still in EX or MEM. It sequences multi-cycle stalls of PC and IF/ID, inserts ID/EX bubbles and squashes the IF/ID instruction after a taken branch. A saturating stall counter provides performance monitoring.

Parameters:
LOAD_EX_STALL, 2, stall cycles when a branch source is the destination of a load currently in EX
LOAD_MEM_STALL, 1, stall cycles when a branch source is the destination of a load currently in MEM
CNT_W, 16, width of the stall performance counter

Ports:
Clk  in  1  pipeline clock, rising edge
Rst  in  1  synchronous, active-high reset
Branch  in  1  ID instruction is a conditional branch
BranchTaken  in  1  ID comparator result, qualified by Branch
UsesRs  in  1  ID instruction (non-branch) reads rfReSel1
UsesRt  in  1  ID instruction (non-branch) reads rfReSel2
rfReSel1  in  5  ID source register 1
rfReSel2  in  5  ID source register 2
RegW_EX  in  1  EX instruction writes the register file
MemR_EX  in  1  EX instruction is a load
EX_rfWeSel  in  5  EX destination register
RegW_MEM  in  1  MEM instruction writes the register file
MemR_MEM  in  1  MEM instruction is a load
MEM_rfWeSel  in  5  MEM destination register
PcWrite  out  1  PC enable
IFID_Write  out  1  IF/ID register enable
IDEX_Bubble  out  1  zero ID/EX control fields this cycle
IFID_Flush  out  1  squash the IF/ID contents at the next edge
StallCnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Hazard match(sel, dst, we, ld) = we && ld && dst!=0 && dst==sel.
- Need computation is combinational in RUN:
  - Branch with a match on EX for rfReSel1 or rfReSel2 -> need = LOAD_EX_STALL.
  - Otherwise, Branch with a match on MEM -> need = LOAD_MEM_STALL.
  - Non-branch with UsesRs/UsesRt matching a load in EX -> need = 1.
  - When both operands hit at different depths, need = max.
- FSM states: RUN, STALL. Registered: state, Left (2 bits).
- RUN, need==0:
  - PcWrite=1, IFID_Write=1, IDEX_Bubble=0.
  - IFID_Flush = Branch && BranchTaken.
- RUN, need>0:
  - Same cycle: PcWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
  - need==1: stay RUN and re-evaluate next cycle.
  - need>1: next state STALL, Left = need-1.
- STALL:
  - PcWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0. Hazard inputs are ignored.
  - Left decrements each cycle. When Left==1 at the edge, next state is RUN.
  - On return to RUN, hazards are re-evaluated. The load will have advanced, so no re-stall occurs unless a new hazard exists.
- Total stall length equals need, e.g. a load in EX feeding a branch gives exactly 2 bubble cycles.
- A taken-branch flush is only asserted in the cycle the branch leaves ID, i.e. RUN with need==0. It never coincides with a stall.
- StallCnt increments by 1 on every cycle with PcWrite==0 and saturates at all-ones.
- Reset (synchronous, sampled at the Clk edge): state=RUN, Left=0, StallCnt=0.
  - While Rst is high, outputs are forced to PcWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
  - Rst asserted mid-STALL aborts the stall at that edge.
- No combinational path from Rst to outputs other than the forcing above. All other outputs are combinational from state and inputs.

Decomposition:
- Shared pipeline package holds:
  - state encoding: RUN=1'b0, STALL=1'b1
  - register-index width 5 and the zero-register constant
- Sub-module sat_counter (CNT_W, enable, synchronous clear) implements StallCnt.
- The hazard compare is repeated logic and is written as a function, not a module.

Test Plan:
- lw r5 in EX (RegW_EX=1, MemR_EX=1, EX_rfWeSel=5), beq with rfReSel1=5 -> PcWrite=0 for exactly 2 cycles, IDEX_Bubble=1 both cycles, StallCnt=2.
- Load r7 in MEM, branch with rfReSel2=7 -> 1 stall cycle, then RUN. With BranchTaken=1 the next cycle has IFID_Flush=1 for 1 cycle.
- Load to r0 in EX with branch on r0 -> no stall, PcWrite=1. Non-load ALU write to r5 in EX -> no stall (covered by forwarding).
- Rs matches a load in MEM and Rt matches a load in EX, both on the same branch -> 2 stall cycles, not 3.
- Rst=1 in the first STALL cycle -> next cycle state=RUN, PcWrite=1, StallCnt=0.
- CNT_W=4 with a continuous hazard stream -> StallCnt holds at 15.
